// File: rtl/mem_channel_controller_if.sv
// Bus bundle for mem_channel_controller: consumer-side request/response
// signals and the per-channel memory-side signals.
// Optional write path: MEM_CTRL_WRITE_EN (write signals exist only when defined).
// Modport slave is the controller's view; modport master is the view of the
// surrounding cores/memory that drive requests and memory responses.
interface mem_channel_controller_if #(
    parameter int NUM_CONSUMERS = 32,
    parameter int NUM_CHANNELS  = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [NUM_CONSUMERS-1:0]                 consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                 consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data;
    logic [NUM_CHANNELS-1:0]                  mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                  mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data;
`ifdef MEM_CTRL_WRITE_EN
    logic [NUM_CONSUMERS-1:0]                 consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                 consumer_write_ready;
    logic [NUM_CHANNELS-1:0]                  mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                  mem_write_ready;
`endif

    modport slave (
`ifdef MEM_CTRL_WRITE_EN
        input  consumer_write_valid, consumer_write_address, consumer_write_data, mem_write_ready,
        output consumer_write_ready, mem_write_valid, mem_write_address, mem_write_data,
`endif
        input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
        output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
    );

    modport master (
`ifdef MEM_CTRL_WRITE_EN
        output consumer_write_valid, consumer_write_address, consumer_write_data, mem_write_ready,
        input  consumer_write_ready, mem_write_valid, mem_write_address, mem_write_data,
`endif
        output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
        input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
    );
endinterface

// File: rtl/mem_channel_controller.sv
// mem_channel_controller: shares NUM_CHANNELS memory channels among
// NUM_CONSUMERS requesters with round-robin arbitration. Each channel owns one
// consumer transaction at a time and relays the response back to it.
// Optional write path: MEM_CTRL_WRITE_EN (undefined = read-only instruction port).
//
// state        | meaning
// S_IDLE       | channel free, may grant a pending consumer this cycle
// S_READ_WAIT  | mem_read_valid high, waiting for mem_read_ready
// S_READ_RELAY | consumer_read_ready high, waiting for consumer to drop read valid
// S_WRITE_WAIT | mem_write_valid high, waiting for mem_write_ready
// S_WRITE_RELAY| consumer_write_ready high, waiting for consumer to drop write valid
module mem_channel_controller #(
    parameter int NUM_CONSUMERS = 32,
    parameter int NUM_CHANNELS  = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_channel_controller_if.slave bus
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

`ifdef MEM_CTRL_WRITE_EN
    typedef enum logic [2:0] {S_IDLE, S_READ_WAIT, S_READ_RELAY, S_WRITE_WAIT, S_WRITE_RELAY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_READ_RELAY} state_t;
`endif

    state_t                                   r_state [NUM_CHANNELS];
    state_t                                   w_state_nxt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][CW-1:0]          r_owner, w_owner_nxt;
    logic [NUM_CONSUMERS-1:0]                 r_busy, w_busy_nxt;
    logic [CW-1:0]                            r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_CHANNELS-1:0]                  r_mem_read_valid, w_mem_read_valid_nxt;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  r_mem_read_address, w_mem_read_address_nxt;
    logic [NUM_CONSUMERS-1:0]                 r_cons_read_ready, w_cons_read_ready_nxt;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] r_cons_read_data, w_cons_read_data_nxt;
`ifdef MEM_CTRL_WRITE_EN
    logic [NUM_CHANNELS-1:0]                  r_mem_write_valid, w_mem_write_valid_nxt;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  r_mem_write_address, w_mem_write_address_nxt;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  r_mem_write_data, w_mem_write_data_nxt;
    logic [NUM_CONSUMERS-1:0]                 r_cons_write_ready, w_cons_write_ready_nxt;
`endif

    logic [NUM_CONSUMERS-1:0] w_request;
    logic [NUM_CONSUMERS-1:0] w_claimed;
    logic                     w_found;
    logic                     w_grant_any;
    logic [CW-1:0]            w_idx;
    logic [CW-1:0]            w_pick;
    int                       w_last_ofs;

`ifdef MEM_CTRL_WRITE_EN
    assign w_request = bus.consumer_read_valid | bus.consumer_write_valid;
`else
    assign w_request = bus.consumer_read_valid;
`endif

    // Arbitration and per-channel next-state: channels resolved in ascending
    // index so a consumer claimed by a lower channel is hidden from higher ones.
    always_comb begin
        w_state_nxt            = r_state;
        w_owner_nxt            = r_owner;
        w_busy_nxt             = r_busy;
        w_rr_ptr_nxt           = r_rr_ptr;
        w_mem_read_valid_nxt   = r_mem_read_valid;
        w_mem_read_address_nxt = r_mem_read_address;
        w_cons_read_ready_nxt  = r_cons_read_ready;
        w_cons_read_data_nxt   = r_cons_read_data;
`ifdef MEM_CTRL_WRITE_EN
        w_mem_write_valid_nxt   = r_mem_write_valid;
        w_mem_write_address_nxt = r_mem_write_address;
        w_mem_write_data_nxt    = r_mem_write_data;
        w_cons_write_ready_nxt  = r_cons_write_ready;
`endif
        w_claimed   = '0;
        w_found     = 1'b0;
        w_grant_any = 1'b0;
        w_idx       = '0;
        w_pick      = '0;
        w_last_ofs  = 0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_found = 1'b0;
            w_pick  = '0;
            case (r_state[ch])
                S_IDLE: begin
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        if (!w_found) begin
                            w_idx = CW'((int'(r_rr_ptr) + k) % NUM_CONSUMERS);
                            if (w_request[w_idx] && !r_busy[w_idx] && !w_claimed[w_idx]) begin
                                w_found = 1'b1;
                                w_pick  = w_idx;
                                if (k > w_last_ofs) w_last_ofs = k;
                            end
                        end
                    end
                    if (w_found) begin
                        w_grant_any         = 1'b1;
                        w_claimed[w_pick]   = 1'b1;
                        w_busy_nxt[w_pick]  = 1'b1;
                        w_owner_nxt[ch]     = w_pick;
`ifdef MEM_CTRL_WRITE_EN
                        if (bus.consumer_read_valid[w_pick]) begin
                            w_state_nxt[ch]            = S_READ_WAIT;
                            w_mem_read_valid_nxt[ch]   = 1'b1;
                            w_mem_read_address_nxt[ch] = bus.consumer_read_address[w_pick];
                        end else begin
                            w_state_nxt[ch]             = S_WRITE_WAIT;
                            w_mem_write_valid_nxt[ch]   = 1'b1;
                            w_mem_write_address_nxt[ch] = bus.consumer_write_address[w_pick];
                            w_mem_write_data_nxt[ch]    = bus.consumer_write_data[w_pick];
                        end
`else
                        w_state_nxt[ch]            = S_READ_WAIT;
                        w_mem_read_valid_nxt[ch]   = 1'b1;
                        w_mem_read_address_nxt[ch] = bus.consumer_read_address[w_pick];
`endif
                    end
                end
                S_READ_WAIT: begin
                    if (bus.mem_read_ready[ch]) begin
                        w_mem_read_valid_nxt[ch]               = 1'b0;
                        w_cons_read_data_nxt[r_owner[ch]]      = bus.mem_read_data[ch];
                        w_cons_read_ready_nxt[r_owner[ch]]     = 1'b1;
                        w_state_nxt[ch]                        = S_READ_RELAY;
                    end
                end
                S_READ_RELAY: begin
                    if (!bus.consumer_read_valid[r_owner[ch]]) begin
                        w_cons_read_ready_nxt[r_owner[ch]] = 1'b0;
                        w_busy_nxt[r_owner[ch]]            = 1'b0;
                        w_state_nxt[ch]                    = S_IDLE;
                    end
                end
`ifdef MEM_CTRL_WRITE_EN
                S_WRITE_WAIT: begin
                    if (bus.mem_write_ready[ch]) begin
                        w_mem_write_valid_nxt[ch]           = 1'b0;
                        w_cons_write_ready_nxt[r_owner[ch]] = 1'b1;
                        w_state_nxt[ch]                     = S_WRITE_RELAY;
                    end
                end
                S_WRITE_RELAY: begin
                    if (!bus.consumer_write_valid[r_owner[ch]]) begin
                        w_cons_write_ready_nxt[r_owner[ch]] = 1'b0;
                        w_busy_nxt[r_owner[ch]]             = 1'b0;
                        w_state_nxt[ch]                     = S_IDLE;
                    end
                end
`endif
                default: w_state_nxt[ch] = S_IDLE;
            endcase
        end
        // Pointer moves just past the furthest consumer reached by any grant.
        if (w_grant_any) w_rr_ptr_nxt = CW'((int'(r_rr_ptr) + w_last_ofs + 1) % NUM_CONSUMERS);
    end

    // State and output registers; reset aborts any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) r_state[ch] <= S_IDLE;
            r_owner            <= '0;
            r_busy             <= '0;
            r_rr_ptr           <= '0;
            r_mem_read_valid   <= '0;
            r_mem_read_address <= '0;
            r_cons_read_ready  <= '0;
            r_cons_read_data   <= '0;
`ifdef MEM_CTRL_WRITE_EN
            r_mem_write_valid   <= '0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_cons_write_ready  <= '0;
`endif
        end else begin
            r_state            <= w_state_nxt;
            r_owner            <= w_owner_nxt;
            r_busy             <= w_busy_nxt;
            r_rr_ptr           <= w_rr_ptr_nxt;
            r_mem_read_valid   <= w_mem_read_valid_nxt;
            r_mem_read_address <= w_mem_read_address_nxt;
            r_cons_read_ready  <= w_cons_read_ready_nxt;
            r_cons_read_data   <= w_cons_read_data_nxt;
`ifdef MEM_CTRL_WRITE_EN
            r_mem_write_valid   <= w_mem_write_valid_nxt;
            r_mem_write_address <= w_mem_write_address_nxt;
            r_mem_write_data    <= w_mem_write_data_nxt;
            r_cons_write_ready  <= w_cons_write_ready_nxt;
`endif
        end
    end

    assign bus.mem_read_valid      = r_mem_read_valid;
    assign bus.mem_read_address    = r_mem_read_address;
    assign bus.consumer_read_ready = r_cons_read_ready;
    assign bus.consumer_read_data  = r_cons_read_data;
`ifdef MEM_CTRL_WRITE_EN
    assign bus.mem_write_valid      = r_mem_write_valid;
    assign bus.mem_write_address    = r_mem_write_address;
    assign bus.mem_write_data       = r_mem_write_data;
    assign bus.consumer_write_ready = r_cons_write_ready;
`endif
endmodule
